// File: rtl/mem_responder.sv
// mem_responder: serial memory responder for a 2-bit-per-cycle CPU link.
// The CPU sends a start cycle, a command, a 16-bit address and, for writes, data.
// The responder serves reads from an internal byte memory. It answers after a
// fixed delay with a start marker followed by the 16-bit word.
//
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   tx_pins[1:0] - request stream from the CPU (LSB-first pairs)
//   rx_pins[1:0] - reply stream to the CPU (01 start marker, then word pairs)
//   busy         - FSM is not in IDLE
//   err          - sticky: nonzero tx_pins seen while waiting or replying
//   load_en/load_addr/load_data - backdoor byte write into memory
module mem_responder #(
  parameter int MEM_ADDR_BITS = 6,
  parameter int RESP_DELAY    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               tx_pins,
  output logic [1:0]               rx_pins,
  output logic                     busy,
  output logic                     err,
  input  logic                     load_en,
  input  logic [MEM_ADDR_BITS-1:0] load_addr,
  input  logic [7:0]               load_data
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WAIT, RSTART, REPLY} state_t;

  // Last value of cnt inside WAIT. It is unused when RESP_DELAY is 0, because
  // WAIT is skipped in that case.
  localparam logic [3:0] WAIT_LAST = (RESP_DELAY == 0) ? 4'd0 : 4'(RESP_DELAY - 1);

  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic [1:0]  cmd;
  logic [15:0] addr, data, word;
  logic [7:0]  mem [0:(1 << MEM_ADDR_BITS)-1];

  logic [3:0]  pair_idx;
  logic        addr_last, data_last, wait_last, reply_last;
  logic [15:0] addr_full, data_full;
  logic [MEM_ADDR_BITS-1:0] rd_a, rd_a1, wr_a, wr_a1;

  assign pair_idx   = {cnt[2:0], 1'b0};
  assign addr_last  = (cnt == 4'd7);
  assign data_last  = (cnt == (cmd[0] ? 4'd3 : 4'd7));
  assign wait_last  = (cnt == WAIT_LAST);
  assign reply_last = (cnt == 4'd7);

  // The top address pair arrives in the same cycle as the read sample, so it
  // is merged from tx_pins instead of taken from the register.
  assign addr_full = {tx_pins, addr[13:0]};
  assign rd_a      = addr_full[MEM_ADDR_BITS-1:0];
  assign rd_a1     = rd_a + MEM_ADDR_BITS'(1);
  assign wr_a      = addr[MEM_ADDR_BITS-1:0];
  assign wr_a1     = wr_a + MEM_ADDR_BITS'(1);

  // Data word including the pair arriving in the final DATA cycle.
  always_comb begin
    data_full = data;
    data_full[pair_idx +: 2] = tx_pins;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    rx_pins   = 2'b00;
    unique case (state)
      IDLE:   if (tx_pins[0]) state_nxt = CMD;
      CMD:    state_nxt = ADDR;
      ADDR:   if (addr_last) begin
                if (cmd[1])               state_nxt = DATA;
                else if (RESP_DELAY == 0) state_nxt = RSTART;
                else                      state_nxt = WAIT;
              end
      DATA:   if (data_last) state_nxt = IDLE;
      WAIT:   if (wait_last) state_nxt = RSTART;
      RSTART: begin
                rx_pins   = 2'b01;
                state_nxt = REPLY;
              end
      REPLY:  begin
                rx_pins = word[pair_idx +: 2];
                if (reply_last) state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      cmd  <= '0;
      addr <= '0;
      data <= '0;
      word <= '0;
      err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE:   cnt <= '0;
        CMD:    begin
                  cmd <= tx_pins;
                  cnt <= '0;
                end
        ADDR:   begin
                  addr[pair_idx +: 2] <= tx_pins;
                  cnt <= addr_last ? 4'd0 : cnt + 4'd1;
                  if (addr_last && !cmd[1])
                    word <= cmd[0] ? {8'h00, mem[rd_a]} : {mem[rd_a1], mem[rd_a]};
                end
        DATA:   begin
                  data[pair_idx +: 2] <= tx_pins;
                  cnt <= data_last ? 4'd0 : cnt + 4'd1;
                end
        WAIT:   cnt <= wait_last ? 4'd0 : cnt + 4'd1;
        RSTART: cnt <= '0;
        REPLY:  cnt <= reply_last ? 4'd0 : cnt + 4'd1;
        default: cnt <= '0;
      endcase
      if ((state == WAIT || state == RSTART || state == REPLY) && tx_pins != 2'b00)
        err <= 1'b1;
    end
  end

  // Memory is not reset. The packet write is placed after the backdoor write,
  // so the packet wins on a same-byte collision. A reset on the final DATA
  // edge suppresses the packet write.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (!reset && state == DATA && data_last) begin
      mem[wr_a] <= data_full[7:0];
      if (!cmd[0]) mem[wr_a1] <= data_full[15:8];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tx;
  logic       load_en;
  logic [5:0] load_addr;
  logic [7:0] load_data;
  logic [1:0] rx0, rx1;
  logic       busy0, busy1, err0, err1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [15:0] w; int c; } exp_t;
  exp_t q0[$], q1[$];
  logic [7:0] m [64];
  bit err_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.MEM_ADDR_BITS(6), .RESP_DELAY(2)) u0 (
    .clk(clk), .reset(reset), .tx_pins(tx), .rx_pins(rx0), .busy(busy0), .err(err0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  mem_responder #(.MEM_ADDR_BITS(6), .RESP_DELAY(0)) u1 (
    .clk(clk), .reset(reset), .tx_pins(tx), .rx_pins(rx1), .busy(busy1), .err(err1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Replies are collected independently of the driver. Each reply start must
  // match the next expected entry, both its cycle and its word.
  task automatic mon(input int i);
    bit col = 0;
    int k = 0;
    logic [15:0] w = '0;
    logic [1:0] r;
    exp_t e;
    forever begin
      @(negedge clk);
      r = (i == 0) ? rx0 : rx1;
      if (col) begin
        w[2*k +: 2] = r;
        k++;
        if (k == 8) begin
          chk($sformatf("reply_word%0d", i), int'(w), int'(e.w));
          col = 0;
        end
      end else if (r == 2'b01) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("spurious_start%0d", i), 1, 0);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rstart_cycle%0d", i), cyc, e.c);
          col = 1;
          k = 0;
        end
      end else if (r != 2'b00) begin
        chk($sformatf("rx_quiet%0d", i), int'(r), 0);
      end
    end
  endtask

  task automatic step(input logic [1:0] v);
    @(negedge clk);
    tx = v;
    load_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      step({1'($urandom), 1'b0});
      if ($urandom_range(0, 2) == 0) begin
        load_en   = 1'b1;
        load_addr = 6'($urandom);
        load_data = 8'($urandom);
        m[load_addr] = load_data;
      end
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [7:0] d);
    step({1'($urandom), 1'b0});
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    m[a] = d;
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d,
                      input bit inj, input bit coll);
    int last;
    logic [5:0] ma;
    logic [15:0] w;
    bit forced;
    exp_t e;
    ma = a[5:0];
    step({1'($urandom), 1'b1});
    chk("busy_idle", int'(busy0), 0);
    step(c);
    chk("busy_cmd", int'(busy0), 1);
    for (int k = 0; k < 8; k++) step(a[2*k +: 2]);
    last = cyc;
    if (c[1]) begin
      for (int k = 0; k < (c[0] ? 4 : 8); k++) step(d[2*k +: 2]);
      if (coll) begin
        load_en = 1'b1;
        load_addr = ma;
        load_data = 8'($urandom);
      end
      m[ma] = d[7:0];
      if (!c[0]) m[ma + 6'd1] = d[15:8];
    end else begin
      w = c[0] ? {8'h00, m[ma]} : {m[ma + 6'd1], m[ma]};
      e.w = w; e.c = last + 3; q0.push_back(e);
      e.c = last + 1; q1.push_back(e);
      forced = inj;
      for (int j = 1; j <= 11; j++) begin
        step(2'b00);
        if (inj && j >= 4 && j <= 9 && (forced || $urandom_range(0, 1) == 1)) begin
          tx = forced ? 2'b01 : 2'($urandom_range(1, 3));
          forced = 0;
          err_exp = 1;
        end
      end
      chk("busy_last_reply", int'(busy0), 1);
      step(2'b00);
      chk("busy_after_reply", int'(busy0), 0);
      chk("err0", int'(err0), int'(err_exp));
      chk("err1", int'(err1), int'(err_exp));
    end
  endtask

  initial begin
    reset = 1'b1;
    tx = 2'b00;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    fork
      mon(0);
      mon(1);
    join_none
    repeat (2) @(negedge clk);
    chk("rst_rx", int'(rx0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_err", int'(err0), 0);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) load(6'(i), 8'($urandom));

    // Write then read back 0xBEEF.
    send(2'd2, 16'h0010, 16'hBEEF, 0, 0);
    chk("beef_lo_model", int'(m[16]), 'hEF);
    send(2'd0, 16'h0010, 16'h0, 0, 0);
    // Wrap-around read across the top of memory.
    load(6'd63, 8'h12);
    load(6'd0, 8'h34);
    send(2'd0, 16'h003F, 16'h0, 0, 0);
    // READ8 zero-extends.
    load(6'd5, 8'hA5);
    send(2'd1, 16'h0005, 16'h0, 0, 0);
    // Back-to-back WRITE8 followed by a read of the same byte.
    send(2'd3, 16'h0021, 16'h0077, 0, 0);
    send(2'd0, 16'h0020, 16'h0, 0, 0);
    // Packet write beats a same-byte backdoor write.
    send(2'd3, 16'h0009, 16'h00C3, 0, 1);
    send(2'd1, 16'h0009, 16'h0, 0, 0);
    // Protocol error during a reply is sticky.
    send(2'd0, 16'h0030, 16'h0, 1, 0);
    idle(3);
    send(2'd1, 16'h0031, 16'h0, 0, 0);

    // Reset during the fourth DATA cycle of WRITE8 aborts the write.
    load(6'd2, 8'h5A);
    step(2'b01);
    step(2'b11);
    for (int k = 0; k < 8; k++) step((k == 0) ? 2'b10 : 2'b00);
    for (int k = 0; k < 3; k++) step(2'b11);
    step(2'b11);
    reset = 1'b1;
    step(2'b00);
    reset = 1'b0;
    err_exp = 0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_err", int'(err0), 0);
    chk("abort_rx", int'(rx0), 0);
    send(2'd1, 16'h0002, 16'h0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] c;
      c = 2'($urandom);
      send(c, 16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0);
      idle($urandom_range(0, 3));
    end

    idle(20);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
